// File: rtl/ir_pulse_counter.sv
// Debounced IR obstacle counter: synchronizes the active-low sensor, accepts
// objects after DEBOUNCE_CYCLES stable cycles and keeps a packed 2-digit BCD tally.
`timescale 1ns/1ps
module ir_pulse_counter #(
  parameter int          DEBOUNCE_CYCLES = 50_000,
  parameter logic [7:0]  MAX_BCD         = 8'h99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ir_in,
  input  logic       clear,
  output logic [7:0] count,
  output logic       count_valid,
  output logic       overflow,
  output logic       object_present
);

  localparam int TW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DEB_ON, PRESENT, DEB_OFF} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [1:0]    sync;
  logic          detect;
  logic          inc;
  logic          wrap;
  logic [7:0]    count_inc;

  // Synchronizer idles high so reset never looks like a detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], ir_in};
  end

  assign detect = ~sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    inc       = 1'b0;
    case (state)
      IDLE:    if (detect) state_nxt = DEB_ON;
      DEB_ON: begin
        if (!detect) state_nxt = IDLE;
        else if (timer == T_LAST) begin
          state_nxt = PRESENT;
          inc       = 1'b1;
        end
      end
      PRESENT: if (!detect) state_nxt = DEB_OFF;
      DEB_OFF: begin
        if (detect)                 state_nxt = PRESENT;
        else if (timer == T_LAST)   state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Timer only runs while debouncing and restarts on any state change.
    if (state_nxt != state || state == IDLE || state == PRESENT) timer_nxt = '0;
    else                                                          timer_nxt = timer + TW'(1);
  end

  always_comb begin
    count_inc = count;
    if (count[3:0] == 4'd9) begin
      count_inc[3:0] = 4'd0;
      count_inc[7:4] = count[7:4] + 4'd1;
    end else begin
      count_inc[3:0] = count[3:0] + 4'd1;
    end
  end

  assign wrap = (count == MAX_BCD);

  // Clear has priority over a same-cycle increment; the FSM still consumes the object.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= 8'h00;
      count_valid <= 1'b0;
      overflow    <= 1'b0;
    end else if (clear) begin
      count       <= 8'h00;
      count_valid <= 1'b0;
      overflow    <= 1'b0;
    end else if (inc) begin
      count       <= wrap ? 8'h00 : count_inc;
      count_valid <= 1'b1;
      overflow    <= overflow | wrap;
    end else begin
      count_valid <= 1'b0;
    end
  end

  assign object_present = (state == PRESENT) || (state == DEB_OFF);

endmodule

// File: tb/tb_ir_pulse_counter.sv
// Scoreboard bench for ir_pulse_counter with DEBOUNCE_CYCLES=4: stimulus pushes
// expected {overflow,count} per accepted object, a monitor pops on count_valid.
`timescale 1ns/1ps
module tb_ir_pulse_counter;
  localparam int DEB = 4;

  logic       clk = 1'b0, rst_n = 1'b0, ir_in = 1'b1, clear = 1'b0;
  logic [7:0] count;
  logic       count_valid, overflow, object_present;

  int         n_chk = 0, n_fail = 0;
  logic [8:0] exp_q[$];
  int         exp_dec = 0;
  logic       exp_ovf = 1'b0;
  logic       prev_cv = 1'b0;

  ir_pulse_counter #(.DEBOUNCE_CYCLES(DEB), .MAX_BCD(8'h99)) dut (
    .clk(clk), .rst_n(rst_n), .ir_in(ir_in), .clear(clear),
    .count(count), .count_valid(count_valid), .overflow(overflow),
    .object_present(object_present)
  );

  always #10 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_inc();
    if (exp_dec == 99) begin
      exp_dec = 0;
      exp_ovf = 1'b1;
    end else exp_dec++;
    exp_q.push_back({exp_ovf, to_bcd(exp_dec)});
  endtask

  task automatic model_clear();
    exp_dec = 0;
    exp_ovf = 1'b0;
  endtask

  task automatic pulse(input int lo, input int hi);
    ir_in = 1'b0; cyc(lo);
    ir_in = 1'b1; cyc(hi);
  endtask

  task automatic good_obj();
    push_inc();
    pulse(8, 10);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin cyc(1); t++; end
    chk("queue_drain", exp_q.size(), 0);
  endtask

  task automatic do_clear();
    clear = 1'b1; cyc(1); clear = 1'b0;
    model_clear();
  endtask

  // Monitor: every count_valid pulse must match the next expected entry.
  always @(negedge clk) begin
    if (rst_n && count_valid) begin
      n_chk++;
      if (prev_cv) begin
        n_fail++;
        $display("FAIL cv_back_to_back: got 2 consecutive pulses, want 1");
      end else if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: got count=%0h, want no pulse", count);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if ({overflow, count} !== e || count[3:0] > 4'd9 || count[7:4] > 4'd9) begin
          n_fail++;
          $display("FAIL pulse_value: got ovf=%0b count=%0h, want ovf=%0b count=%0h",
                   overflow, count, e[8], e[7:0]);
        end
      end
    end
    prev_cv <= rst_n & count_valid;
  end

  initial begin
    #1ms;
    n_fail++;
    $display("FAIL timeout: got no finish, want finish within 1 ms");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    cyc(2);
    chk("rst_count", count, 8'h00);
    chk("rst_cv", count_valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_present", object_present, 0);
    rst_n = 1'b1;
    cyc(2);

    // Long object: latency and presence window
    push_inc();
    ir_in = 1'b0;
    cyc(6);
    chk("lat_cv_early", count_valid, 0);
    chk("lat_present_early", object_present, 0);
    cyc(1);
    chk("lat_cv_edge6", count_valid, 1);
    chk("lat_count_edge6", count, 8'h01);
    chk("lat_present_edge6", object_present, 1);
    cyc(13);
    ir_in = 1'b1;
    cyc(6);
    chk("release_present_held", object_present, 1);
    cyc(1);
    chk("release_present_drop", object_present, 0);
    cyc(4);

    // Short pulse rejected; glitch inside a long object gives one count
    pulse(3, 10);
    push_inc();
    ir_in = 1'b0; cyc(14);
    ir_in = 1'b1; cyc(2);
    ir_in = 1'b0; cyc(14);
    ir_in = 1'b1; cyc(10);
    drain();
    chk("glitch_count", count, 8'h02);

    // BCD carry
    do_clear();
    chk("clear_count", count, 8'h00);
    repeat (9) good_obj();
    drain();
    chk("bcd_09", count, 8'h09);
    good_obj();
    drain();
    chk("bcd_10", count, 8'h10);

    // Wrap at 99
    while (exp_dec != 99) good_obj();
    drain();
    chk("bcd_99", count, 8'h99);
    chk("ovf_before_wrap", overflow, 0);
    good_obj();
    drain();
    chk("wrap_count", count, 8'h00);
    chk("wrap_ovf", overflow, 1);
    do_clear();
    chk("clear_ovf", overflow, 0);
    chk("clear_count2", count, 8'h00);

    // Clear colliding with an increment
    good_obj();
    drain();
    ir_in = 1'b0;
    cyc(6);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    model_clear();
    chk("collide_count", count, 8'h00);
    chk("collide_cv", count_valid, 0);
    chk("collide_present", object_present, 1);
    ir_in = 1'b1;
    cyc(10);

    // Reset in the middle of DEB_ON
    good_obj();
    drain();
    ir_in = 1'b0;
    cyc(5);
    rst_n = 1'b0;
    #1;
    chk("midrst_count", count, 8'h00);
    chk("midrst_cv", count_valid, 0);
    chk("midrst_ovf", overflow, 0);
    chk("midrst_present", object_present, 0);
    model_clear();
    cyc(2);
    rst_n = 1'b1;
    push_inc();
    cyc(6);
    chk("postrst_cv_early", count_valid, 0);
    cyc(1);
    chk("postrst_cv_edge6", count_valid, 1);
    chk("postrst_count", count, 8'h01);
    ir_in = 1'b1;
    cyc(10);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ir_pulse_counter.md
IR_PULSE_COUNTER -- requirements
Module: ir_pulse_counter

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 50_000 (1 ms at 50 MHz): the number of consecutive stable cycles required to accept an edge; legal values are 2 or more.
REQ-002 The block SHALL have parameter MAX_BCD, default 8'h99: the highest count value before wrap, packed 2-digit BCD.
REQ-003 Port clk SHALL be an input, width 1: the system clock, on whose rising edge all state changes.
REQ-004 Port rst_n SHALL be an input, width 1: asynchronous, active-low reset.
REQ-005 Port ir_in SHALL be an input, width 1: raw infrared obstacle sensor; low means object detected; asynchronous to clk.
REQ-006 Port clear SHALL be an input, width 1: synchronous count clear, active-high.
REQ-007 Port count SHALL be an output, width 8: packed BCD count; bits [7:4] are tens, bits [3:0] are units; registered.
REQ-008 Port count_valid SHALL be an output, width 1: one-cycle pulse in the cycle count takes a new incremented value.
REQ-009 Port overflow SHALL be an output, width 1: sticky flag, set when count wraps.
REQ-010 Port object_present SHALL be an output, width 1: high while an object is accepted as present (states PRESENT and DEB_OFF).

Function
REQ-011 ir_in SHALL pass through a 2-flop synchronizer; detect is defined as the inverted second flop.
REQ-012 The FSM SHALL have exactly four states: IDLE, DEB_ON, PRESENT, DEB_OFF; a timer of ceil(log2(DEBOUNCE_CYCLES)) bits SHALL clear on every state change.
REQ-013 In IDLE, detect=1 SHALL go to DEB_ON; otherwise the FSM SHALL stay in IDLE.
REQ-014 In DEB_ON, detect=0 SHALL return to IDLE with no count.
REQ-015 In DEB_ON, with timer==DEBOUNCE_CYCLES-1 and detect=1, the FSM SHALL go to PRESENT and increment count; otherwise timer SHALL increment.
REQ-016 In PRESENT, detect=0 SHALL go to DEB_OFF; otherwise the FSM SHALL stay in PRESENT.
REQ-017 In DEB_OFF, detect=1 SHALL return to PRESENT with no count.
REQ-018 In DEB_OFF, with timer==DEBOUNCE_CYCLES-1 and detect=0, the FSM SHALL go to IDLE; otherwise timer SHALL increment.
REQ-019 Latency: if ir_in is first sampled low at edge 0 and held low, count update and count_valid=1 SHALL occur at edge DEBOUNCE_CYCLES+2.
REQ-020 A low pulse on ir_in shorter than DEBOUNCE_CYCLES cycles after synchronization SHALL produce no increment and no count_valid.
REQ-021 Only one increment SHALL occur per accepted object, regardless of how long it stays present or how much glitching occurs during DEB_OFF.
REQ-022 Increment SHALL be BCD: the units digit goes 9->0 and carries into tens; neither digit ever holds a value of A–F.
REQ-023 Increment from MAX_BCD SHALL wrap count to 8'h00, set overflow, and still pulse count_valid.
REQ-024 clear=1 SHALL set count=8'h00 and overflow=0 on the next edge, with count_valid=0 in that cycle; the FSM state and timer SHALL be unaffected.
REQ-025 When clear and an increment occur in the same cycle, clear SHALL win: count=8'h00, count_valid=0, and the object is consumed (FSM goes to PRESENT).
REQ-026 count_valid SHALL never be high for two consecutive cycles.

Reset
REQ-027 While rst_n=0, the synchronizer flops SHALL be 1 (no detect), state=IDLE, timer=0, count=8'h00, count_valid=0, overflow=0, object_present=0, all asynchronously.
REQ-028 Reset asserted in any state, including mid-debounce, SHALL abort that state without an increment.
REQ-029 After rst_n deasserts, the first accepted object SHALL require the full debounce time.

Verification (DEBOUNCE_CYCLES=4, clk 50 MHz)
REQ-030 Drive ir_in low for 20 cycles, then high -> count 8'h00->8'h01 at edge 6, one count_valid pulse, object_present high from edge 6 until 4 stable-high cycles after release.
REQ-031 Drive ir_in low for 3 cycles, then high; then a 30-cycle low with a 2-cycle high glitch in the middle -> count ends at 8'h01, exactly one count_valid.
REQ-032 Apply 9 then 10 clean objects from 8'h00 -> count reads 8'h09, then 8'h10, and never shows an A–F digit.
REQ-033 Preload to 8'h99 via 99 objects, then 1 more -> count=8'h00, overflow=1, count_valid pulses; then clear=1 for one cycle -> overflow=0, count=8'h00.
REQ-034 Assert clear in the same cycle as the edge-6 increment -> count=8'h00, count_valid=0, object_present=1.
REQ-035 Assert rst_n=0 at cycle 3 of DEB_ON, then release it while ir_in is still low -> all outputs 0, and the increment occurs 6 edges after the first post-reset sampling edge.
